lcd_ctrl: RTL and testbench
===========================

# lcd_ctrl

Byte sequencer sitting directly upstream of the SPI byte transmitter in the Nokia 5110 driver. After reset it waits a power-up delay, then sends the PCD8544 initialisation commands. On each refresh request it sends the address-set commands and streams the 504-byte framebuffer from a synchronous-read memory. It sends one byte at a time through the transmitter's enable/ready handshake.

## Interface
Parameters:
- INIT_DELAY, 16, cycles after nrst release before the first byte; minimum 1
- VOP, 7'h31, contrast value; command byte = 8'h80 | VOP
- BIAS, 3'd4, bias system; command byte = 8'h10 | BIAS
- TEMPC, 2'd0, temperature coefficient; command byte = 8'h04 | TEMPC

Ports:
- clk  in  1  system clock; also the SPI bit clock source
- nrst  in  1  reset, asynchronous, active-low
- refresh  in  1  one-cycle pulse requesting a full frame write
- busy  out  1  high from reset until the end of init, and during any frame
- frame_done  out  1  one-cycle pulse after the last data byte is accepted
- fb_addr  out  9  framebuffer read address, 0..503
- fb_data  in  8  framebuffer read data, valid one cycle after fb_addr
- spi_data  out  8  byte to transmitter, MSB sent first
- spi_mode  out  1  1 = command, 0 = display data
- spi_enable  out  1  one-cycle request strobe
- spi_ready  in  1  transmitter idle

## Operation
- Reset values: busy=1, frame_done=0, fb_addr=0, spi_data=0, spi_mode=0, spi_enable=0, pending=0.
- States:
  - DELAY: counts INIT_DELAY cycles, then goes to INIT.
  - INIT: sends 6 command bytes in order 8'h21, 8'h80|VOP, 8'h04|TEMPC, 8'h10|BIAS, 8'h20, 8'h0C. After the last byte: busy←0, go to IDLE.
  - IDLE: if refresh or pending is set, clear pending, set busy←1, go to SETX.
  - SETX: sends 8'h80 (command).
  - SETY: sends 8'h40 (command), then fb_addr←0 and go to FETCH.
  - FETCH: drives fb_addr for one cycle.
  - SEND: issues fb_data as display data (mode 0). If fb_addr==503: fb_addr←0, frame_done pulses, busy←0, go to IDLE. Otherwise fb_addr+1, go to FETCH.
- Byte issue sub-sequence, shared by every send:
  - ISSUE: entered only when spi_ready=1. Loads spi_data/spi_mode and asserts spi_enable for exactly one cycle.
  - HOLD: one cycle in which spi_ready is ignored, because the transmitter captures the byte in this cycle.
  - WAITRDY: waits for spi_ready=1, then advances.
- spi_data/spi_mode stay stable from ISSUE until the next ISSUE.
- spi_enable is never asserted while spi_ready=0 or outside ISSUE.
- A refresh arriving while busy=1 (during DELAY, INIT or a frame) sets pending. Multiple requests collapse into one; pending is serviced from IDLE.
- A refresh in the same cycle as frame_done is latched as pending.
- nrst asserted mid-operation: all outputs return to reset values at once. After release, the full DELAY+INIT runs again; the LCD receives the same reset through the transmitter.
- fb_addr wraps 503→0 and never exceeds 503.

## Timing
- First spi_enable occurs INIT_DELAY+1 cycles after the first clk edge with nrst=1.
- Per-byte overhead: ISSUE (1 cycle) + HOLD (1 cycle) + wait until spi_ready rises.
  - Data bytes add FETCH (1 cycle) because memory read latency is 1 cycle.
- refresh in IDLE leads to SETX's ISSUE 1 cycle later.
- frame_done is asserted in the cycle after WAITRDY sees spi_ready=1 for byte 503. busy falls in the same cycle.
- Frame length: 2 command bytes + 504 data bytes.

## Structure
- Package lcd_pkg holds:
  - PCD8544 command constants: FUNC_EXT 8'h21, FUNC_BASIC 8'h20, DISP_NORMAL 8'h0C, SET_X 8'h80, SET_Y 8'h40.
  - FB_BYTES=504 and FB_AW=9.
  - The state enum.
- Init command list: function init_cmd(index) in lcd_pkg; no ROM sub-module.
- Single module; no sub-module. The byte-issue sub-sequence is states inside the main FSM.

## Test plan
- Release nrst with a bus-functional transmitter model (ready low 9 cycles after enable) → no spi_enable for 16 cycles, then exactly 0x21,0xB1,0x04,0x14,0x20,0x0C with mode=1. busy falls after 0x0C.
- refresh pulse, framebuffer word n = n[7:0]^8'hA5 → 0x80,0x40 (mode 1), then 504 bytes 0xA5,0xA4,… (mode 0). fb_addr runs 0..503 then returns to 0. Exactly one frame_done.
- Model holds spi_ready low 40 cycles per byte → spi_enable never high while ready=0. spi_data is stable through HOLD. Byte sequence is unchanged.
- Three refresh pulses during INIT and one mid-frame → exactly one frame after INIT and exactly one more after the first frame. A refresh coincident with frame_done → one further frame.
- nrst low while sending data byte 100 → all outputs hit reset values asynchronously. After release, the sequence restarts at 0x21 after 16 idle cycles; no data byte appears before init completes.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants, FSM state encoding and the PCD8544 init command list
// for the Nokia 5110 byte sequencer.
package lcd_pkg;

  localparam logic [7:0] FUNC_EXT    = 8'h21;
  localparam logic [7:0] FUNC_BASIC  = 8'h20;
  localparam logic [7:0] DISP_NORMAL = 8'h0C;
  localparam logic [7:0] SET_X       = 8'h80;
  localparam logic [7:0] SET_Y       = 8'h40;

  localparam int FB_BYTES = 504;
  localparam int FB_AW    = 9;
  localparam int INIT_LEN = 6;

  typedef enum logic [3:0] {
    ST_DELAY,
    ST_INIT,
    ST_IDLE,
    ST_SETX,
    ST_SETY,
    ST_FETCH,
    ST_SEND,
    ST_ISSUE,
    ST_HOLD,
    ST_WAITRDY
  } state_t;

  // Extended-set commands (VOP/TEMPC/BIAS) sit between FUNC_EXT and FUNC_BASIC.
  function automatic logic [7:0] init_cmd(input logic [2:0] idx,
                                          input logic [6:0] vop,
                                          input logic [2:0] bias,
                                          input logic [1:0] tempc);
    case (idx)
      3'd0:    init_cmd = FUNC_EXT;
      3'd1:    init_cmd = 8'h80 | {1'b0, vop};
      3'd2:    init_cmd = 8'h04 | {6'b0, tempc};
      3'd3:    init_cmd = 8'h10 | {5'b0, bias};
      3'd4:    init_cmd = FUNC_BASIC;
      default: init_cmd = DISP_NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/lcd_ctrl.sv
// PCD8544 byte sequencer: power-up delay, init commands, then full-frame
// writes on request, one byte at a time through the SPI enable/ready handshake.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned INIT_DELAY = 16,
  parameter logic [6:0]  VOP        = 7'h31,
  parameter logic [2:0]  BIAS       = 3'd4,
  parameter logic [1:0]  TEMPC      = 2'd0
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             refresh,
  output logic             busy,
  output logic             frame_done,
  output logic [FB_AW-1:0] fb_addr,
  input  logic [7:0]       fb_data,
  output logic [7:0]       spi_data,
  output logic             spi_mode,
  output logic             spi_enable,
  input  logic             spi_ready
);

  localparam int CNT_W = (INIT_DELAY > 1) ? $clog2(INIT_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(INIT_DELAY - 1);
  localparam logic [FB_AW-1:0] ADDR_LAST = FB_AW'(FB_BYTES - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(INIT_LEN - 1);

  state_t             state_q;
  state_t             ret_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         idx_q;
  logic               busy_q;
  logic               frame_done_q;
  logic [FB_AW-1:0]   fb_addr_q;
  logic [7:0]         spi_data_q;
  logic               spi_mode_q;
  logic               spi_enable_q;
  logic               pending_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= ST_DELAY;
      ret_q        <= ST_INIT;
      cnt_q        <= '0;
      idx_q        <= '0;
      busy_q       <= 1'b1;
      frame_done_q <= 1'b0;
      fb_addr_q    <= '0;
      spi_data_q   <= '0;
      spi_mode_q   <= 1'b0;
      spi_enable_q <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      spi_enable_q <= 1'b0;
      if (refresh && busy_q) pending_q <= 1'b1;

      case (state_q)
        ST_DELAY: begin
          if (cnt_q == CNT_LAST) state_q <= ST_INIT;
          else                   cnt_q   <= cnt_q + 1'b1;
        end

        // Every byte-producing state issues only once the transmitter is idle
        // and remembers itself so WAITRDY knows where to resume.
        ST_INIT, ST_SETX, ST_SETY, ST_SEND: begin
          if (spi_ready) begin
            spi_enable_q <= 1'b1;
            ret_q        <= state_q;
            state_q      <= ST_ISSUE;
            case (state_q)
              ST_INIT: begin
                spi_data_q <= init_cmd(idx_q, VOP, BIAS, TEMPC);
                spi_mode_q <= 1'b1;
              end
              ST_SETX: begin
                spi_data_q <= SET_X;
                spi_mode_q <= 1'b1;
              end
              ST_SETY: begin
                spi_data_q <= SET_Y;
                spi_mode_q <= 1'b1;
              end
              default: begin
                spi_data_q <= fb_data;
                spi_mode_q <= 1'b0;
              end
            endcase
          end
        end

        ST_IDLE: begin
          if (refresh || pending_q) begin
            pending_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= ST_SETX;
          end
        end

        ST_FETCH: state_q <= ST_SEND;
        ST_ISSUE: state_q <= ST_HOLD;
        // Ready is ignored here: the transmitter is still capturing the byte.
        ST_HOLD:  state_q <= ST_WAITRDY;

        ST_WAITRDY: begin
          if (spi_ready) begin
            case (ret_q)
              ST_INIT: begin
                if (idx_q == IDX_LAST) begin
                  idx_q   <= '0;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
                end else begin
                  idx_q   <= idx_q + 3'd1;
                  state_q <= ST_INIT;
                end
              end
              ST_SETX: state_q <= ST_SETY;
              ST_SETY: begin
                fb_addr_q <= '0;
                state_q   <= ST_FETCH;
              end
              default: begin
                if (fb_addr_q == ADDR_LAST) begin
                  fb_addr_q    <= '0;
                  frame_done_q <= 1'b1;
                  busy_q       <= 1'b0;
                  state_q      <= ST_IDLE;
                end else begin
                  fb_addr_q <= fb_addr_q + 1'b1;
                  state_q   <= ST_FETCH;
                end
              end
            endcase
          end
        end

        default: state_q <= ST_DELAY;
      endcase
    end
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign fb_addr    = fb_addr_q;
  assign spi_data   = spi_data_q;
  assign spi_mode   = spi_mode_q;
  assign spi_enable = spi_enable_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl with a bus-functional SPI transmitter and a
// framebuffer whose word n holds n[7:0]^8'hA5.
module tb_lcd_ctrl;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       refresh = 1'b0;
  logic       busy, frame_done;
  logic [8:0] fb_addr;
  logic [7:0] fb_data;
  logic [7:0] spi_data;
  logic       spi_mode, spi_enable;
  logic       spi_ready;

  int         ready_lat = 9;
  int         rdy_cnt;
  logic [8:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         fd_cnt = 0;
  int         bytes_seen = 0;
  int         data_seen = 0;
  logic [8:0] last_byte = '0;
  bit         hold_chk = 1'b0;

  lcd_ctrl dut (
    .clk        (clk),
    .nrst       (nrst),
    .refresh    (refresh),
    .busy       (busy),
    .frame_done (frame_done),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .spi_data   (spi_data),
    .spi_mode   (spi_mode),
    .spi_enable (spi_enable),
    .spi_ready  (spi_ready)
  );

  always #5 clk = ~clk;

  // Transmitter: drops ready for ready_lat cycles after accepting a byte.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      spi_ready <= 1'b1;
      rdy_cnt   <= 0;
    end else if (spi_enable && spi_ready) begin
      spi_ready <= 1'b0;
      rdy_cnt   <= ready_lat - 1;
    end else if (!spi_ready) begin
      if (rdy_cnt == 0) spi_ready <= 1'b1;
      else              rdy_cnt   <= rdy_cnt - 1;
    end
  end

  always @(posedge clk) fb_data <= fb_addr[7:0] ^ 8'hA5;

  task automatic push_init();
    exp_q.push_back({1'b1, 8'h21});
    exp_q.push_back({1'b1, 8'hB1});
    exp_q.push_back({1'b1, 8'h04});
    exp_q.push_back({1'b1, 8'h14});
    exp_q.push_back({1'b1, 8'h20});
    exp_q.push_back({1'b1, 8'h0C});
  endtask

  task automatic push_frame();
    logic [8:0] n;
    exp_q.push_back({1'b1, 8'h80});
    exp_q.push_back({1'b1, 8'h40});
    for (int i = 0; i < 504; i++) begin
      n = 9'(i);
      exp_q.push_back({1'b0, n[7:0] ^ 8'hA5});
    end
  endtask

  task automatic pulse_refresh();
    @(negedge clk);
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
  endtask

  // Watches every issued byte: handshake legality, order/content, hold stability.
  task automatic monitor();
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        hold_chk = 1'b0;
      end else begin
        if (hold_chk) begin
          checks++;
          if (spi_enable !== 1'b0 || {spi_mode, spi_data} !== last_byte) begin
            errors++;
            $display("FAIL hold_stable: en=%b mode/data=%h required en=0 mode/data=%h",
                     spi_enable, {spi_mode, spi_data}, last_byte);
          end
          hold_chk = 1'b0;
        end
        if (frame_done === 1'b1) fd_cnt++;
        if (spi_enable === 1'b1) begin
          checks++;
          if (spi_ready !== 1'b1) begin
            errors++;
            $display("FAIL enable_while_busy: spi_ready=%b required 1", spi_ready);
          end
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_byte: got mode/data=%h, no byte expected", {spi_mode, spi_data});
          end else begin
            e = exp_q.pop_front();
            if ({spi_mode, spi_data} !== e) begin
              errors++;
              $display("FAIL byte_%0d: got mode/data=%h required %h", bytes_seen, {spi_mode, spi_data}, e);
            end
          end
          checks++;
          if (fb_addr > 9'd503) begin
            errors++;
            $display("FAIL fb_addr_range: got %0d required <=503", fb_addr);
          end
          last_byte = {spi_mode, spi_data};
          hold_chk  = 1'b1;
          bytes_seen++;
          if (spi_mode === 1'b0) data_seen++;
        end
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, frame_done, fb_addr, spi_data, spi_mode, spi_enable} !== {1'b1, 1'b0, 9'd0, 8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: busy=%b fd=%b addr=%0d data=%h mode=%b en=%b required 1 0 0 00 0 0",
               busy, frame_done, fb_addr, spi_data, spi_mode, spi_enable);
    end
    push_init();
    nrst = 1'b1;
    ok = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk);
      #1;
      if (k < 17 && spi_enable !== 1'b0) ok = 1'b0;
      if (k == 17 && spi_enable !== 1'b1) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL init_delay: first spi_enable not at edge 17 after release (en=%b)", spi_enable);
    end
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL init_timeout: busy=%b required 0", busy);
    end
    @(negedge clk);
    checks++;
    if (bytes_seen != 6 || exp_q.size() != 0 || last_byte !== {1'b1, 8'h0C}) begin
      errors++;
      $display("FAIL init_sequence: bytes=%0d left=%0d last=%h required 6 0 10c",
               bytes_seen, exp_q.size(), last_byte);
    end
    $display("test_reset: init sequence issued %0d bytes", bytes_seen);
  endtask

  task automatic run_frame(input string name, input int bound);
    int  fd0;
    bit  ok;
    fd0 = fd_cnt;
    push_frame();
    pulse_refresh();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy_rise: busy=%b required 1", name, busy);
    end
    @(negedge clk);
    checks++;
    if (spi_enable !== 1'b1) begin
      errors++;
      $display("FAIL %s_setx_latency: spi_enable=%b required 1", name, spi_enable);
    end
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (fd_cnt != fd0) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: frame_done count=%0d required %0d", name, fd_cnt - fd0, 1);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (fd_cnt - fd0 != 1 || exp_q.size() != 0 || busy !== 1'b0 || fb_addr !== 9'd0) begin
      errors++;
      $display("FAIL %s_end: frames=%0d left=%0d busy=%b addr=%0d required 1 0 0 0",
               name, fd_cnt - fd0, exp_q.size(), busy, fb_addr);
    end
    $display("%s: frame finished, total bytes seen %0d", name, bytes_seen);
  endtask

  task automatic test_frame();
    ready_lat = 9;
    run_frame("test_frame", 10000);
  endtask

  task automatic test_slow_ready();
    ready_lat = 40;
    run_frame("test_slow_ready", 30000);
  endtask

  task automatic test_pending();
    int fd0, d0, b0;
    bit ok;
    ready_lat = 3;
    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    exp_q.delete();
    push_init();
    push_frame();
    push_frame();
    fd0 = fd_cnt;
    b0  = bytes_seen;
    nrst = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bytes_seen != b0) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL pending_init_start: no byte within 100 cycles");
    end
    repeat (3) pulse_refresh();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL pending_during_init: busy=%b required 1", busy);
    end
    d0 = data_seen;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (data_seen - d0 >= 50) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL pending_first_frame: data bytes=%0d required >=50", data_seen - d0);
    end
    pulse_refresh();
    ok = 1'b0;
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      if (fd_cnt - fd0 >= 2) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL pending_timeout: frames=%0d required 2", fd_cnt - fd0);
    end
    repeat (100) @(negedge clk);
    checks++;
    if (fd_cnt - fd0 != 2 || exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pending_count: frames=%0d left=%0d busy=%b required 2 0 0",
               fd_cnt - fd0, exp_q.size(), busy);
    end
    $display("test_pending: %0d frames after init", fd_cnt - fd0);
  endtask

  task automatic test_coincident_refresh();
    int fd0;
    bit ok;
    ready_lat = 3;
    fd0 = fd_cnt;
    push_frame();
    push_frame();
    pulse_refresh();
    ok = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin ok = 1'b1; break; end
    end
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL coincident_first: frame_done never seen");
    end
    ok = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (fd_cnt - fd0 >= 2) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL coincident_timeout: frames=%0d required 2", fd_cnt - fd0);
    end
    repeat (100) @(negedge clk);
    checks++;
    if (fd_cnt - fd0 != 2 || exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL coincident_count: frames=%0d left=%0d busy=%b required 2 0 0",
               fd_cnt - fd0, exp_q.size(), busy);
    end
    $display("test_coincident_refresh: %0d frames", fd_cnt - fd0);
  endtask

  task automatic test_async_reset();
    int d0, dr;
    bit ok;
    ready_lat = 3;
    push_frame();
    d0 = data_seen;
    pulse_refresh();
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (data_seen - d0 >= 101) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL async_reach_byte100: data bytes=%0d required 101", data_seen - d0);
    end
    @(posedge clk);
    @(posedge clk);
    #3;
    nrst = 1'b0;
    #1;
    checks++;
    if ({busy, frame_done, fb_addr, spi_data, spi_mode, spi_enable} !== {1'b1, 1'b0, 9'd0, 8'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset_values: busy=%b fd=%b addr=%0d data=%h mode=%b en=%b required 1 0 0 00 0 0",
               busy, frame_done, fb_addr, spi_data, spi_mode, spi_enable);
    end
    exp_q.delete();
    push_init();
    repeat (2) @(negedge clk);
    dr = data_seen;
    nrst = 1'b1;
    ok = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk);
      #1;
      if (k < 17 && spi_enable !== 1'b0) ok = 1'b0;
      if (k == 17 && (spi_enable !== 1'b1 || spi_data !== 8'h21 || spi_mode !== 1'b1)) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL async_restart: en=%b data=%h mode=%b required first 0x21 cmd at edge 17",
               spi_enable, spi_data, spi_mode);
    end
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
    repeat (20) @(negedge clk);
    checks++;
    if (!ok || exp_q.size() != 0 || data_seen != dr || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reinit: done=%b left=%0d data_bytes=%0d busy=%b required 1 0 0 0",
               ok, exp_q.size(), data_seen - dr, busy);
    end
    $display("test_async_reset: reinit complete");
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_frame();
    test_slow_ready();
    test_pending();
    test_coincident_refresh();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
